// File: rtl/egg_timer_keys_if.sv
// Purpose : key-conditioner bundle between board KEY pins and the timer core.
// Latency : n/a (wires only).
// Backpr. : none; every output is a level or a single-cycle pulse.
//
// Ports (signals):
//   KEY          raw active-low board keys (0 = pressed)
//   key_level    debounced key state, 1 = pressed
//   key_press    one-cycle pulse on the debounced press edge
//   key_release  one-cycle pulse on the debounced release edge
//   rep_pulse    one-cycle auto-repeat pulse for the set key
//   set_step     key_press[set key] OR rep_pulse
// master = board/stimulus side, slave = conditioner side.
interface egg_timer_keys_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                rep_pulse;
  logic                set_step;

  modport master (
    output KEY,
    input  key_level, key_press, key_release, rep_pulse, set_step
  );

  modport slave (
    input  KEY,
    output key_level, key_press, key_release, rep_pulse, set_step
  );
endinterface

// File: rtl/egg_timer_keys.sv
// Purpose : debounce active-low board keys, emit press/release pulses and set-key auto-repeat.
// Latency : raw change -> key_level/edge pulse after DB_CYCLES+2 clocks; all outputs registered.
// Backpr. : none; pulses are fire-and-forget single cycles.
//
// Ports:
//   CLOCK_50  system clock (rising edge)
//   reset     synchronous active-high reset
//   keys      egg_timer_keys_if.slave: KEY in; key_level, key_press,
//             key_release, rep_pulse, set_step out
//
// The repeat FSM is driven from the debounce next-state values so it moves
// on the same edge as key_press/key_level; that makes a release on a timer
// expiry edge suppress the pulse, and keeps rep_pulse aligned with set_step.
module egg_timer_keys #(
  parameter int NUM_KEYS   = 3,
  parameter int DB_CYCLES  = 500000,
  parameter int CNT_W      = 20,
  parameter int REP_KEY    = 1,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter int REP_W      = 25
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  egg_timer_keys_if.slave keys
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, sync_pressed;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  rep_state_e          state_q, state_d;
  logic [REP_W-1:0]    tmr_q, tmr_d;
  logic                rep_q, rep_d;
  logic                step_q, step_d;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= keys.KEY;
      sync2_q <= sync1_q;
    end
  end

  assign sync_pressed = ~sync2_q;

  // Debounce: count consecutive cycles the synchronized key disagrees with
  // the accepted level; any agreement restarts the count.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync_pressed[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i]   = ~level_q[i];
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Repeat FSM: the timer holds cycles elapsed since the press edge (DELAY)
  // or since the last pulse (REPEAT).
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + REP_W'(1);
    rep_d   = 1'b0;
    if (!level_d[REP_KEY]) begin
      state_d = IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmr_d = '0;
          if (press_d[REP_KEY]) begin
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (tmr_q == DELAY_LAST) begin
            rep_d   = 1'b1;
            state_d = REPEAT;
            tmr_d   = '0;
          end
        end
        REPEAT: begin
          if (tmr_q == PERIOD_LAST) begin
            rep_d = 1'b1;
            tmr_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    step_d = press_d[REP_KEY] | rep_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
      state_q   <= IDLE;
      tmr_q     <= '0;
      rep_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      rep_q     <= rep_d;
      step_q    <= step_d;
    end
  end

  assign keys.key_level   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;
  assign keys.rep_pulse   = rep_q;
  assign keys.set_step    = step_q;

endmodule

// File: tb/tb_egg_timer_keys.sv
// Purpose : directed self-checking bench for egg_timer_keys (DB=4, delay 10, period 3).
// Latency : edges are numbered from 1 = first edge after a stimulus change.
// Backpr. : none.
module tb_egg_timer_keys;

  localparam int NK = 3;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errs;

  egg_timer_keys_if #(.NUM_KEYS(NK)) kif ();

  egg_timer_keys #(
    .NUM_KEYS  (NK),
    .DB_CYCLES (4),
    .CNT_W     (3),
    .REP_KEY   (1),
    .REP_DELAY (10),
    .REP_PERIOD(3),
    .REP_W     (4)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .keys    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int n,
                            input logic [2:0] lvl, input logic [2:0] prs,
                            input logic [2:0] rel, input logic rep, input logic stp);
    chk($sformatf("%s@%0d level", tag, n),   8'(kif.key_level),   8'(lvl));
    chk($sformatf("%s@%0d press", tag, n),   8'(kif.key_press),   8'(prs));
    chk($sformatf("%s@%0d release", tag, n), 8'(kif.key_release), 8'(rel));
    chk($sformatf("%s@%0d rep", tag, n),     8'(kif.rep_pulse),   8'(rep));
    chk($sformatf("%s@%0d step", tag, n),    8'(kif.set_step),    8'(stp));
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic rp;
    logic pr;
    n_checks = 0;
    n_errs   = 0;

    // 1: reset with all keys pressed -> everything 0, nothing after release.
    reset   = 1'b1;
    kif.KEY = 3'b000;
    for (int n = 1; n <= 2; n++) begin
      step();
      check_outs("rst", n, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    end
    reset   = 1'b0;
    kif.KEY = 3'b111;
    for (int n = 1; n <= 8; n++) begin
      step();
      check_outs("idle", n, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
    end

    // 2: KEY[2] press then release, 6 edges each.
    kif.KEY = 3'b011;
    for (int n = 1; n <= 8; n++) begin
      step();
      check_outs("k2p", n, (n >= 6) ? 3'b100 : 3'b000, (n == 6) ? 3'b100 : 3'b000,
                 3'b000, 1'b0, 1'b0);
    end
    kif.KEY = 3'b111;
    for (int n = 1; n <= 8; n++) begin
      step();
      check_outs("k2r", n, (n < 6) ? 3'b100 : 3'b000, 3'b000,
                 (n == 6) ? 3'b100 : 3'b000, 1'b0, 1'b0);
    end

    // 3: KEY[0] bounces low3/high1 x5, then held.
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < 4; c++) begin
        kif.KEY = (c < 3) ? 3'b110 : 3'b111;
        step();
        check_outs("bnc", b * 4 + c, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      end
    end
    kif.KEY = 3'b110;
    for (int n = 1; n <= 8; n++) begin
      step();
      check_outs("k0p", n, (n >= 6) ? 3'b001 : 3'b000, (n == 6) ? 3'b001 : 3'b000,
                 3'b000, 1'b0, 1'b0);
    end
    kif.KEY = 3'b111;
    for (int n = 1; n <= 8; n++) begin
      step();
      check_outs("k0r", n, (n < 6) ? 3'b001 : 3'b000, 3'b000,
                 (n == 6) ? 3'b001 : 3'b000, 1'b0, 1'b0);
    end

    // 4: KEY[1] held 30 edges: press at 6, repeats at 16,19,...; release after.
    kif.KEY = 3'b101;
    for (int n = 1; n <= 30; n++) begin
      step();
      pr = (n == 6);
      rp = (n >= 16) && ((n - 16) % 3 == 0);
      check_outs("rep", n, (n >= 6) ? 3'b010 : 3'b000, pr ? 3'b010 : 3'b000,
                 3'b000, rp, pr | rp);
    end
    kif.KEY = 3'b111;
    for (int m = 1; m <= 10; m++) begin
      step();
      rp = ((30 + m - 16) % 3 == 0) && (m < 6);
      check_outs("reprel", 30 + m, (m < 6) ? 3'b010 : 3'b000, 3'b000,
                 (m == 6) ? 3'b010 : 3'b000, rp, rp);
    end

    // 5: release lands on the expiry edge 22 -> no pulse there, none after.
    for (int n = 1; n <= 30; n++) begin
      kif.KEY = (n <= 16) ? 3'b101 : 3'b111;
      step();
      pr = (n == 6);
      rp = (n == 16) || (n == 19);
      check_outs("race", n, (n >= 6 && n < 22) ? 3'b010 : 3'b000, pr ? 3'b010 : 3'b000,
                 (n == 22) ? 3'b010 : 3'b000, rp, pr | rp);
    end

    // 6: KEY[1] held, reset sampled at edge 12; press again at 18, repeats 28,31,34.
    kif.KEY = 3'b101;
    for (int n = 1; n <= 34; n++) begin
      reset = (n == 12);
      step();
      if (n < 12) begin
        pr = (n == 6);
        check_outs("midrst", n, (n >= 6) ? 3'b010 : 3'b000, pr ? 3'b010 : 3'b000,
                   3'b000, 1'b0, pr);
      end else if (n == 12) begin
        check_outs("midrst", n, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      end else begin
        pr = (n == 18);
        rp = (n == 28) || (n == 31) || (n == 34);
        check_outs("midrst", n, (n >= 18) ? 3'b010 : 3'b000, pr ? 3'b010 : 3'b000,
                   3'b000, rp, pr | rp);
      end
    end
    reset   = 1'b0;
    kif.KEY = 3'b111;
    for (int m = 1; m <= 8; m++) begin
      step();
      rp = (m == 3);
      check_outs("rstrel", 34 + m, (m < 6) ? 3'b010 : 3'b000, 3'b000,
                 (m == 6) ? 3'b010 : 3'b000, rp, rp);
    end

    // 7: all keys together, independent and simultaneous; released before any repeat.
    kif.KEY = 3'b000;
    for (int n = 1; n <= 7; n++) begin
      step();
      pr = (n == 6);
      check_outs("allp", n, (n >= 6) ? 3'b111 : 3'b000, pr ? 3'b111 : 3'b000,
                 3'b000, 1'b0, pr);
    end
    kif.KEY = 3'b111;
    for (int n = 1; n <= 8; n++) begin
      step();
      check_outs("allr", n, (n < 6) ? 3'b111 : 3'b000, 3'b000,
                 (n == 6) ? 3'b111 : 3'b000, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
